usr_shift_sequencer: RTL

//  Command-driven controller for the 4-bit universal shift register. Accepts load/clear/rotate

---
 rtl/usr_seq_pkg.sv | 21 ++
 rtl/usr_shift_sequencer.sv | 113 +++++++++++
 2 files changed

// File: rtl/usr_seq_pkg.sv
// Shared constants for the universal shift register sequencer:
// command opcodes, register mode codes and FSM state encoding.
package usr_seq_pkg;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_LD  = 2'b11;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_ROTR = 2'b01;
  localparam logic [1:0] MODE_ROTL = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/usr_shift_sequencer.sv
// Command-driven Moore controller for an external 4-bit universal shift register.
// Optional macro USR_SEQ_CNT_WRAP_EN reduces rotate counts modulo WIDTH.
module usr_shift_sequencer
  import usr_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             usr_rst,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_data,
  input  logic [WIDTH-1:0] usr_q
);

  // Both channels use plain valid/ready: a transfer happens on a rising edge
  // where valid && ready; the command side is ready only in IDLE, and the
  // response holds valid and data stable until the host takes it.

  state_t             state, state_nx;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   data_q;
  logic [CNT_W-1:0]   rem_q;
  logic [CNT_W-1:0]   eff_cnt;
  logic               cmd_fire;
  logic               is_rot;

`ifdef USR_SEQ_CNT_WRAP_EN
  // Whole rotations are no-ops, so only the low log2(WIDTH) bits matter.
  assign eff_cnt = cmd_cnt & CNT_W'(WIDTH - 1);
`else
  assign eff_cnt = cmd_cnt;
`endif

  assign cmd_fire = cmd_valid && (state == ST_IDLE);
  assign is_rot   = (cmd_op == OP_ROR) || (cmd_op == OP_ROL);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (!is_rot)             state_nx = ST_LOAD;
          else if (eff_cnt != '0)  state_nx = ST_SHIFT;
          else                     state_nx = ST_RESP;
        end
      end
      ST_LOAD:  state_nx = ST_RESP;
      ST_SHIFT: if (rem_q == CNT_W'(1)) state_nx = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      data_q <= '0;
      rem_q  <= '0;
    end else begin
      state <= state_nx;
      if (cmd_fire) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        rem_q  <= eff_cnt;
      end else if (state == ST_SHIFT) begin
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    busy      = (state != ST_IDLE);
    usr_rst   = 1'b0;
    usr_mode  = MODE_HOLD;
    usr_data  = '0;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_LOAD: begin
        if (op_q == OP_LD) begin
          usr_mode = MODE_LOAD;
          usr_data = data_q;
        end else begin
          usr_rst = 1'b1;
        end
      end
      ST_SHIFT: begin
        usr_mode = (op_q == OP_ROR) ? MODE_ROTR : MODE_ROTL;
        usr_data = usr_q;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = usr_q;
      end
      default: ;
    endcase
  end

endmodule
